// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one WIDTH-bit trial subtraction per clock,
// WIDTH iterations per operation, with results and a one-cycle done strobe.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q, d_q, r_q;
    logic [CW-1:0]    count_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic [WIDTH:0]   t_w, s_w;
    logic [WIDTH-1:0] q_d, r_d;

    // One shift-subtract step; a borrow out of the top bit means restore.
    always_comb begin
        t_w = {r_q, q_q[WIDTH-1]};
        s_w = t_w - {1'b0, d_q};
        q_d = {q_q[WIDTH-2:0], ~s_w[WIDTH]};
        r_d = s_w[WIDTH] ? t_w[WIDTH-1:0] : s_w[WIDTH-1:0];
    end

    // NOTE: every register in this block uses <= so all of them update from the
    // same pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q_q     <= dividend;
                            d_q     <= divisor;
                            r_q     <= '0;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: the driver pushes expected results,
// a monitor pops and compares on every done strobe.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                check("busy_done_exclusive", 32'(busy), 32'd0);
                check("pending_on_done", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Drives one start on the next negedge and measures latency and busy length.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
        exp_t e;
        int   lat;
        int   busy_n;
        bit   seen;
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        e.q = eq; e.r = er; e.dbz = ed;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("done_seen %0d/%0d", a, b), 32'(seen), 32'd1);
        check($sformatf("latency %0d/%0d", a, b), 32'(lat), ed ? 32'd1 : 32'(W + 1));
        check($sformatf("busy_cycles %0d/%0d", a, b), 32'(busy_n), ed ? 32'd0 : 32'(W));
    endtask

    initial begin
        exp_t e;
        int   busy_n;
        bit   seen;

        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 13 / 3
        op(4'd13, 4'd3, 4'b0100, 4'b0001, 1'b0);
        // Back-to-back on the first legal cycle
        op(4'd15, 4'd1, 4'b1111, 4'b0000, 1'b0);
        op(4'd5, 4'd7, 4'b0000, 4'b0101, 1'b0);
        // Divide by zero, then a normal op clears the flag
        op(4'd9, 4'd0, 4'b1111, 4'b1001, 1'b1);
        op(4'd8, 4'd2, 4'b0100, 4'b0000, 1'b0);

        // 13 / 3 with stray starts during RUN and DONE
        @(negedge clk);
        e.q = 4'b0100; e.r = 4'b0001; e.dbz = 1'b0;
        sb.push_back(e);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        dividend = 4'd6; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("ignored_start_done_seen", 32'(seen), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        check("ignored_start_no_busy", 32'(busy_n), 32'd0);
        check("ignored_start_quotient", 32'(quotient), 32'b0100);
        check("ignored_start_remainder", 32'(remainder), 32'b0001);

        // Reset in the middle of 14 / 5 after two iterations
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op(4'd14, 4'd5, 4'b0010, 4'b0100, 1'b0);

        // Exhaustive sweep against the arithmetic definition
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    op(W'(a), W'(b), 4'b1111, W'(a), 1'b1);
                else
                    op(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
